mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
Multi-cycle load/store unit that consumes the memory commands issued by the control unit and services them over a word-wide req/ack data bus. It sits between the datapath and data memory. It performs byte-lane steering on stores and lane extraction plus sign/zero extension on loads. While an access is outstanding it stalls the core.

Parameters:
TIMEOUT, 16, maximum BUSY cycles awaiting bus_ack before the access is aborted (1..255).

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high reset
MemWrite  in  1  store request from control unit
MemRead  in  1  load request (datapath asserts when ResultSrc selects memory)
LST  in  3  load/store type (funct3): [1:0] size 00 byte, 01 half, 10 word, 11 illegal
LSE  in  1  1 = sign-extend load result, 0 = zero-extend
Addr  in  32  byte address (ALUResult)
WriteData  in  32  store data (rs2)
ReadData  out  32  extended load result, registered
Stall  out  1  hold PC/pipeline this cycle
MisalignFault  out  1  one-cycle pulse: misaligned or illegal-size access
BusErr  out  1  one-cycle pulse: bus timeout abort
bus_req  out  1  bus request, registered
bus_we  out  1  1 = write
bus_addr  out  32  word-aligned address {Addr[31:2],2'b00}
bus_wstrb  out  4  byte write strobes
bus_wdata  out  32  lane-replicated store data
bus_rdata  in  32  read word, valid with bus_ack
bus_ack  in  1  transfer complete

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; timeout counter 0. Reset mid-access drops bus_req at once; the access is discarded and the next access starts clean.
- access = MemWrite | MemRead. If both are high, the access is a store.
- Alignment: half requires Addr[0]=0; word requires Addr[1:0]=0; size 11 is always illegal.
- FSM states: IDLE, BUSY, DONE.
- IDLE + access + legal: Stall=1 combinationally. Latch we, word address, offset Addr[1:0], size, LSE, strobes and wdata. Next state BUSY.
- IDLE + access + illegal: MisalignFault=1 that cycle; Stall=0; no bus transaction; ReadData<=0; stay IDLE.
- BUSY:
  - bus_req=1 and Stall=1.
  - bus_we, bus_addr, bus_wstrb and bus_wdata are held stable.
  - bus_ack is sampled every BUSY cycle, including the first.
  - On ack: capture the load result into ReadData (stores leave ReadData unchanged); bus_req<=0; go to DONE.
  - The counter increments each BUSY cycle without ack. When it reaches TIMEOUT: bus_req<=0, BusErr pulse, ReadData<=0, go to DONE.
- DONE: Stall=0 so the core retires the instruction. The still-present request is ignored, and the state goes unconditionally to IDLE; the counter clears.
- bus_ack outside BUSY is ignored.
- Latency: zero-wait ack gives 3 cycles per access (IDLE stall, BUSY, DONE); each wait cycle adds 1.
- Store strobes:
  - byte: 4'b0001<<off.
  - half: 4'b0011<<(2*off[1]).
  - word: 4'b1111.
- Store wdata:
  - byte: {4{WriteData[7:0]}}.
  - half: {2{WriteData[15:0]}}.
  - word: WriteData.
- Load extraction:
  - byte: bus_rdata[8*off +: 8].
  - half: bus_rdata[16*off[1] +: 16].
  - word: the whole word.
  - Then extend to 32 bits using LSE. LSE is ignored for word.
- ReadData holds its value until the next load completes or a fault occurs.

Test Plan:
- SW Addr=0x100, WriteData=0xDEADBEEF, ack after 2 wait cycles -> bus_req high for 3 cycles with bus_addr=0x100, bus_we=1, bus_wstrb=1111; Stall high for 4 cycles total, then low in DONE.
- LB (LST=000, LSE=1) Addr=0x203, bus_rdata=0x80112233, zero-wait ack -> ReadData=0xFFFFFF80 in DONE; bus_addr=0x200.
- LHU (LST=101, LSE=0) Addr=0x206, bus_rdata=0xBEEF1234 -> ReadData=0x0000BEEF; SB Addr=0x301, WriteData=0x5A -> bus_wstrb=0010, bus_wdata=0x5A5A5A5A.
- LW Addr=0x102 -> MisalignFault pulse, Stall=0, bus_req never asserted, ReadData=0; LST[1:0]=11 at any address -> same.
- LW with no ack, TIMEOUT=16 -> bus_req high exactly 16 cycles, BusErr single pulse, ReadData=0, FSM returns to IDLE.
- Assert reset during BUSY -> bus_req, Stall and ReadData go 0 immediately; after release, a new SW completes normally with correct strobes.

Source files
------------

// File: rtl/mem_lsu.sv
// -----------------------------------------------------------------------------
// mem_lsu -- multi-cycle load/store unit
//
// Takes the load/store command issued by the control unit and performs it as
// one transfer on a word-wide req/ack bus. Stores get byte-lane steering: the
// data is replicated across the lanes and strobes select the lanes written.
// Loads get lane extraction followed by sign or zero extension. The core is
// stalled while a transfer is outstanding. A misaligned or illegal-size access
// raises a fault and never reaches the bus. If the bus does not acknowledge
// within TIMEOUT cycles, the transfer is abandoned.
//
// Ports
//   clk            core clock, rising edge
//   reset          asynchronous, active-high reset
//   MemWrite       store request
//   MemRead        load request (a store wins when both are high)
//   LST[2:0]       load/store type; [1:0] size 00 byte, 01 half, 10 word, 11 illegal
//   LSE            1 = sign-extend load result, 0 = zero-extend
//   Addr[31:0]     byte address
//   WriteData[31:0] store data
//   ReadData[31:0] extended load result, registered
//   Stall          hold the PC/pipeline this cycle
//   MisalignFault  one-cycle pulse on a misaligned or illegal-size access
//   BusErr         one-cycle pulse (in the DONE cycle) on a bus timeout abort
//   bus_req        bus request, registered
//   bus_we         1 = write transfer
//   bus_addr[31:0] word-aligned address
//   bus_wstrb[3:0] byte write strobes (zero for loads)
//   bus_wdata[31:0] lane-replicated store data
//   bus_rdata[31:0] read word, valid with bus_ack
//   bus_ack        transfer complete
// -----------------------------------------------------------------------------
module mem_lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [2:0]  LST,
  input  logic        LSE,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MisalignFault,
  output logic        BusErr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Abort is decided in the BUSY cycle whose count is TIMEOUT-1, so the
  // request stays up for exactly TIMEOUT cycles.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  // Byte strobes for a store of the given size at byte offset off.
  function automatic logic [3:0] f_strobe(input logic [1:0] size,
                                          input logic [1:0] off);
    logic [3:0] s;
    case (size)
      SZ_BYTE: s = 4'b0001 << off;
      SZ_HALF: s = off[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Store data replicated across every lane the size could address.
  function automatic logic [31:0] f_wdata(input logic [1:0]  size,
                                          input logic [31:0] d);
    logic [31:0] w;
    case (size)
      SZ_BYTE: w = {4{d[7:0]}};
      SZ_HALF: w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Lane extraction from the bus word, then sign/zero extension.
  function automatic logic [31:0] f_load(input logic [1:0]  size,
                                         input logic [1:0]  off,
                                         input logic        sext,
                                         input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: r = sext ? {{24{b[7]}}, b} : {24'd0, b};
      SZ_HALF: r = sext ? {{16{h[15]}}, h} : {16'd0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_wstrb;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_rdata;
  logic        r_buserr;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_lse;
  logic [7:0]  r_cnt;

  logic        w_access;
  logic        w_legal;
  logic        w_stall;
  logic        w_fault;
  logic        w_start;
  logic        w_ack;
  logic        w_tmo;
  logic        w_unused;

  assign w_access = MemWrite | MemRead;
  // LST[2] is the unsigned flag of funct3; extension is driven by LSE instead.
  assign w_unused = LST[2];

  always_comb begin
    w_legal = 1'b0;
    case (LST[1:0])
      SZ_BYTE: w_legal = 1'b1;
      SZ_HALF: w_legal = ~Addr[0];
      SZ_WORD: w_legal = (Addr[1:0] == 2'b00);
      default: w_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-cycle control
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_fault     = 1'b0;
    w_start     = 1'b0;
    w_ack       = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          if (w_legal) begin
            w_stall     = 1'b1;
            w_start     = 1'b1;
            w_state_nxt = S_BUSY;
          end else begin
            w_fault = 1'b1;
          end
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (bus_ack) begin
          w_ack       = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_cnt == TMO_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      // The request is still asserted here; it belongs to the access just
      // retired, so it is ignored.
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Combinational outputs are masked by reset so they drop immediately.
  assign Stall         = w_stall & ~reset;
  assign MisalignFault = w_fault & ~reset;

  // Bus side and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'd0;
      r_bus_wstrb <= 4'd0;
      r_bus_wdata <= 32'd0;
      r_rdata     <= 32'd0;
      r_buserr    <= 1'b0;
      r_off       <= 2'd0;
      r_size      <= 2'd0;
      r_lse       <= 1'b0;
      r_cnt       <= 8'd0;
    end else begin
      r_buserr <= w_tmo;
      if (w_start) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= MemWrite;
        r_bus_addr  <= {Addr[31:2], 2'b00};
        r_bus_wstrb <= MemWrite ? f_strobe(LST[1:0], Addr[1:0]) : 4'd0;
        r_bus_wdata <= f_wdata(LST[1:0], WriteData);
        r_off       <= Addr[1:0];
        r_size      <= LST[1:0];
        r_lse       <= LSE;
      end
      if (w_fault) begin
        r_rdata <= 32'd0;
      end
      if (w_ack) begin
        r_bus_req <= 1'b0;
        if (!r_bus_we) begin
          r_rdata <= f_load(r_size, r_off, r_lse, bus_rdata);
        end
      end
      if (w_tmo) begin
        r_bus_req <= 1'b0;
        r_rdata   <= 32'd0;
      end
      // Counts consecutive un-acked BUSY cycles; zero everywhere else.
      if ((r_state == S_BUSY) && !bus_ack) begin
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_cnt <= 8'd0;
      end
    end
  end

  assign ReadData  = r_rdata;
  assign BusErr    = r_buserr;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wstrb = r_bus_wstrb;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_lsu -- directed self-checking bench for mem_lsu (TIMEOUT = 16)
// -----------------------------------------------------------------------------
module tb_mem_lsu;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic        MemRead;
  logic [2:0]  LST;
  logic        LSE;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        MisalignFault;
  logic        BusErr;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  mem_lsu #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .LST          (LST),
    .LSE          (LSE),
    .Addr         (Addr),
    .WriteData    (WriteData),
    .ReadData     (ReadData),
    .Stall        (Stall),
    .MisalignFault(MisalignFault),
    .BusErr       (BusErr),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wstrb    (bus_wstrb),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Observations gathered by do_access
  int          o_req;
  int          o_stall;
  int          o_mis;
  int          o_berr;
  logic [31:0] o_addr;
  logic        o_we;
  logic [3:0]  o_wstrb;
  logic [31:0] o_wdata;
  logic [31:0] o_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one command and plays the memory: acks after `waits` request
  // cycles. Holds the command until the first cycle with Stall low, then
  // drops it and observes two idle cycles.
  task automatic do_access(input logic we, input logic rd, input logic [2:0] lst,
                           input logic lse, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rdata,
                           input int waits);
    bit ended;
    MemWrite  = we;
    MemRead   = rd;
    LST       = lst;
    LSE       = lse;
    Addr      = addr;
    WriteData = wd;
    bus_rdata = rdata;
    o_req = 0; o_stall = 0; o_mis = 0; o_berr = 0;
    o_addr = 32'd0; o_we = 1'b0; o_wstrb = 4'd0; o_wdata = 32'd0;
    ended = 1'b0;
    for (int cyc = 0; cyc < 40 && !ended; cyc++) begin
      bus_ack = bus_req && (o_req == waits);
      @(negedge clk);
      if (Stall) o_stall++;
      if (MisalignFault) o_mis++;
      if (BusErr) o_berr++;
      if (bus_req) begin
        o_req++;
        o_addr  = bus_addr;
        o_we    = bus_we;
        o_wstrb = bus_wstrb;
        o_wdata = bus_wdata;
      end
      if (!Stall) ended = 1'b1;
      else step();
    end
    if (!ended) chk("access_bound", 32'd0, 32'd1);
    step();
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    bus_ack  = 1'b0;
    o_rd     = ReadData;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (Stall) o_stall++;
      if (bus_req) o_req++;
      if (MisalignFault) o_mis++;
      if (BusErr) o_berr++;
    end
    step();
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; LST = 3'd0; LSE = 1'b0;
    Addr = 32'd0; WriteData = 32'd0; bus_rdata = 32'd0; bus_ack = 1'b0;
    step();
    step();
    chk("rst_req",   32'(bus_req), 32'd0);
    chk("rst_stall", 32'(Stall), 32'd0);
    chk("rst_rdata", ReadData, 32'd0);
    chk("rst_berr",  32'(BusErr), 32'd0);
    chk("rst_mis",   32'(MisalignFault), 32'd0);
    chk("rst_wstrb", 32'(bus_wstrb), 32'd0);
    reset = 1'b0;
    step();

    // SW 0x100, two wait cycles
    do_access(1'b1, 1'b0, 3'b010, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 2);
    chk("sw_req_cyc",   o_req, 32'd3);
    chk("sw_stall_cyc", o_stall, 32'd4);
    chk("sw_addr",      o_addr, 32'h100);
    chk("sw_we",        32'(o_we), 32'd1);
    chk("sw_wstrb",     32'(o_wstrb), 32'hF);
    chk("sw_wdata",     o_wdata, 32'hDEADBEEF);
    chk("sw_mis",       o_mis, 32'd0);
    chk("sw_berr",      o_berr, 32'd0);

    // LB 0x203 signed, zero wait
    do_access(1'b0, 1'b1, 3'b000, 1'b1, 32'h203, 32'h0, 32'h80112233, 0);
    chk("lb_rdata",     o_rd, 32'hFFFFFF80);
    chk("lb_addr",      o_addr, 32'h200);
    chk("lb_we",        32'(o_we), 32'd0);
    chk("lb_req_cyc",   o_req, 32'd1);
    chk("lb_stall_cyc", o_stall, 32'd2);

    // LHU 0x206
    do_access(1'b0, 1'b1, 3'b101, 1'b0, 32'h206, 32'h0, 32'hBEEF1234, 1);
    chk("lhu_rdata", o_rd, 32'h0000BEEF);
    chk("lhu_addr",  o_addr, 32'h204);

    // SB 0x301; ReadData must survive a store
    do_access(1'b1, 1'b0, 3'b000, 1'b0, 32'h301, 32'h0000005A, 32'hFFFFFFFF, 0);
    chk("sb_wstrb", 32'(o_wstrb), 32'h2);
    chk("sb_wdata", o_wdata, 32'h5A5A5A5A);
    chk("sb_addr",  o_addr, 32'h300);
    chk("sb_keep_rdata", o_rd, 32'h0000BEEF);

    // LW misaligned
    do_access(1'b0, 1'b1, 3'b010, 1'b0, 32'h102, 32'h0, 32'h12345678, 0);
    chk("lwmis_fault", o_mis, 32'd1);
    chk("lwmis_stall", o_stall, 32'd0);
    chk("lwmis_req",   o_req, 32'd0);
    chk("lwmis_rdata", o_rd, 32'd0);

    // LBU 0x203, then illegal size 11 at an aligned address
    do_access(1'b0, 1'b1, 3'b100, 1'b0, 32'h203, 32'h0, 32'h80112233, 0);
    chk("lbu_rdata", o_rd, 32'h00000080);
    do_access(1'b0, 1'b1, 3'b011, 1'b0, 32'h0, 32'h0, 32'h12345678, 0);
    chk("ill_fault", o_mis, 32'd1);
    chk("ill_req",   o_req, 32'd0);
    chk("ill_stall", o_stall, 32'd0);
    chk("ill_rdata", o_rd, 32'd0);

    // LH 0x202 signed, then LW with no ack -> timeout
    do_access(1'b0, 1'b1, 3'b001, 1'b1, 32'h202, 32'h0, 32'h80112233, 0);
    chk("lh_rdata", o_rd, 32'hFFFF8011);
    do_access(1'b0, 1'b1, 3'b010, 1'b0, 32'h500, 32'h0, 32'h11111111, 1000);
    chk("tmo_req_cyc",   o_req, 32'd16);
    chk("tmo_stall_cyc", o_stall, 32'd17);
    chk("tmo_berr",      o_berr, 32'd1);
    chk("tmo_rdata",     o_rd, 32'd0);
    chk("tmo_idle_req",  32'(bus_req), 32'd0);

    // Reset in the middle of a BUSY load
    do_access(1'b0, 1'b1, 3'b010, 1'b0, 32'h600, 32'h0, 32'hCAFEF00D, 0);
    chk("lw_rdata", o_rd, 32'hCAFEF00D);
    MemRead = 1'b1; LST = 3'b010; Addr = 32'h604; bus_ack = 1'b0;
    step();
    step();
    step();
    chk("mid_req",   32'(bus_req), 32'd1);
    chk("mid_stall", 32'(Stall), 32'd1);
    chk("mid_rdata", ReadData, 32'hCAFEF00D);
    reset = 1'b1;
    #1;
    chk("arst_req",   32'(bus_req), 32'd0);
    chk("arst_stall", 32'(Stall), 32'd0);
    chk("arst_rdata", ReadData, 32'd0);
    step();
    reset   = 1'b0;
    MemRead = 1'b0;
    step();

    // SH 0x302 after reset
    do_access(1'b1, 1'b0, 3'b001, 1'b0, 32'h302, 32'h1234ABCD, 32'h0, 1);
    chk("sh_req_cyc", o_req, 32'd2);
    chk("sh_addr",    o_addr, 32'h300);
    chk("sh_wstrb",   32'(o_wstrb), 32'hC);
    chk("sh_wdata",   o_wdata, 32'hABCDABCD);
    chk("sh_we",      32'(o_we), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected %0d", 0, 1);
    $fatal(1, "bench time limit");
  end

endmodule
